mips_cpu_bus_arbiter: RTL and testbench

Shares the CPU's single Avalon-style memory port between two requesters: the instruction-fetch requester and the data (load/store) requester.
- Arbitrates between them round-robin.
- Drives and holds the bus signals until waitrequest clears.
- Generates byteenable and lane-aligned writedata for byte/half/word stores.
- Returns extracted, sign- or zero-extended load data with a one-cycle acknowledge.
- Sits between the CPU core's fetch/exec sequencing and the external bus.

---
 rtl/mips_cpu_bus_pkg.sv | 21 ++
 rtl/mips_cpu_bus_lane_align.sv | 46 ++++
 rtl/mips_cpu_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mips_cpu_bus_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_bus_pkg.sv
// Shared types for the CPU bus arbiter: access sizes, arbiter FSM states and grant owners.
package mips_cpu_bus_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } size_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC  = 2'b01,
      RESP = 2'b10
   } state_t;

   typedef enum logic {
      INSTR = 1'b0,
      DATA  = 1'b1
   } grant_t;

endpackage

// File: rtl/mips_cpu_bus_lane_align.sv
// Byte-lane logic for a 32-bit bus: alignment check, byteenable/writedata steering and
// load extraction with sign or zero extension.
module mips_cpu_bus_lane_align
   import mips_cpu_bus_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   input  logic [31:0] readdata,
   output logic        misaligned,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   output logic [31:0] rdata
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v     = readdata[{addr_lo, 3'b000} +: 8];
      half_v     = addr_lo[1] ? readdata[31:16] : readdata[15:0];
      misaligned = 1'b0;
      byteenable = 4'hF;
      writedata  = wdata;
      rdata      = readdata;
      case (size)
         SIZE_BYTE: begin
            byteenable = 4'b0001 << addr_lo;
            writedata  = {4{wdata[7:0]}};
            rdata      = {{24{sign_ext & byte_v[7]}}, byte_v};
         end
         SIZE_HALF: begin
            misaligned = addr_lo[0];
            byteenable = 4'b0011 << addr_lo;
            writedata  = {2{wdata[15:0]}};
            rdata      = {{16{sign_ext & half_v[15]}}, half_v};
         end
         // Word and the unused encoding both behave as a full-word access.
         default: begin
            misaligned = (addr_lo != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-style memory port between instruction fetch and
// load/store requesters; all outputs registered.
module mips_cpu_bus_arbiter
   import mips_cpu_bus_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              active,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic              i_err,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic              d_signed,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic              d_err,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] address,
   output logic              read,
   output logic              write,
   output logic [3:0]        byteenable,
   output logic [DATA_W-1:0] writedata,
   input  logic [DATA_W-1:0] readdata,
   input  logic              waitrequest,
   output logic              busy
);

   state_t      state_q;
   grant_t      last_grant_q;
   logic [1:0]  cur_addr_lo_q;
   logic [1:0]  cur_size_q;
   logic        cur_signed_q;

   logic              grant_valid;
   grant_t            win;
   logic [ADDR_W-1:0] win_addr;
   logic              win_we;

   logic [1:0]        al_addr_lo;
   logic [1:0]        al_size;
   logic              al_signed;
   logic              al_misaligned;
   logic [3:0]        al_be;
   logic [DATA_W-1:0] al_wdata;
   logic [DATA_W-1:0] al_rdata;

   always_comb begin
      grant_valid = 1'b0;
      win         = DATA;
      if (state_q == IDLE && active) begin
         if (i_req && d_req) begin
            grant_valid = 1'b1;
            win         = (last_grant_q == DATA) ? INSTR : DATA;
         end else if (d_req) begin
            grant_valid = 1'b1;
            win         = DATA;
         end else if (i_req) begin
            grant_valid = 1'b1;
            win         = INSTR;
         end
      end
      win_addr = (win == INSTR) ? i_addr : d_addr;
      win_we   = (win == DATA) && d_we;

      // Lane logic sees the candidate in IDLE and the latched owner while the access is open.
      if (state_q == IDLE) begin
         al_addr_lo = win_addr[1:0];
         al_size    = (win == INSTR) ? SIZE_WORD : d_size;
         al_signed  = (win == DATA) && d_signed;
      end else begin
         al_addr_lo = cur_addr_lo_q;
         al_size    = cur_size_q;
         al_signed  = cur_signed_q;
      end
   end

   mips_cpu_bus_lane_align u_lane_align (
      .addr_lo    (al_addr_lo),
      .size       (al_size),
      .sign_ext   (al_signed),
      .wdata      (d_wdata),
      .readdata   (readdata),
      .misaligned (al_misaligned),
      .byteenable (al_be),
      .writedata  (al_wdata),
      .rdata      (al_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         last_grant_q  <= INSTR;
         cur_addr_lo_q <= 2'b00;
         cur_size_q    <= 2'b00;
         cur_signed_q  <= 1'b0;
         i_ack         <= 1'b0;
         i_err         <= 1'b0;
         i_rdata       <= '0;
         d_ack         <= 1'b0;
         d_err         <= 1'b0;
         d_rdata       <= '0;
         address       <= '0;
         read          <= 1'b0;
         write         <= 1'b0;
         byteenable    <= 4'h0;
         writedata     <= '0;
         busy          <= 1'b0;
      end else begin
         i_ack <= 1'b0;
         i_err <= 1'b0;
         d_ack <= 1'b0;
         d_err <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_valid) begin
                  if (al_misaligned) begin
                     if (win == INSTR) i_err <= 1'b1;
                     else              d_err <= 1'b1;
                  end else begin
                     state_q       <= ACC;
                     busy          <= 1'b1;
                     last_grant_q  <= win;
                     cur_addr_lo_q <= al_addr_lo;
                     cur_size_q    <= al_size;
                     cur_signed_q  <= al_signed;
                     address       <= {win_addr[ADDR_W-1:2], 2'b00};
                     read          <= !win_we;
                     write         <= win_we;
                     byteenable    <= al_be;
                     writedata     <= win_we ? al_wdata : '0;
                  end
               end
            end
            ACC: begin
               if (!waitrequest) begin
                  state_q   <= RESP;
                  read      <= 1'b0;
                  write     <= 1'b0;
                  writedata <= '0;
                  if (last_grant_q == INSTR) begin
                     i_ack   <= 1'b1;
                     i_rdata <= al_rdata;
                  end else begin
                     d_ack <= 1'b1;
                     if (!write) d_rdata <= al_rdata;
                  end
               end
            end
            RESP: begin
               state_q <= IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Self-checking bench: vector table for single accesses, scoreboard for responses, and
// directed sequences for round-robin, reset-abort and active gating.
module tb_mips_cpu_bus_arbiter;
   import mips_cpu_bus_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        active = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_ack, i_err;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [1:0]  d_size = 2'b00;
   logic        d_signed = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_ack, d_err;
   logic [31:0] d_rdata;
   logic [31:0] address;
   logic        read, write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic [31:0] readdata = '0;
   logic        waitrequest = 1'b0;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mips_cpu_bus_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .active      (active),
      .i_req       (i_req),
      .i_addr      (i_addr),
      .i_ack       (i_ack),
      .i_err       (i_err),
      .i_rdata     (i_rdata),
      .d_req       (d_req),
      .d_we        (d_we),
      .d_size      (d_size),
      .d_signed    (d_signed),
      .d_addr      (d_addr),
      .d_wdata     (d_wdata),
      .d_ack       (d_ack),
      .d_err       (d_err),
      .d_rdata     (d_rdata),
      .address     (address),
      .read        (read),
      .write       (write),
      .byteenable  (byteenable),
      .writedata   (writedata),
      .readdata    (readdata),
      .waitrequest (waitrequest),
      .busy        (busy)
   );

   typedef struct {
      logic        is_d;
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;
      logic        exp_err;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      logic [31:0] exp_rd;
   } vec_t;

   // kind: 0 = i_ack, 1 = d_ack, 2 = i_err, 3 = d_err
   typedef struct {
      logic [1:0]  kind;
      logic        chk;
      logic [31:0] rd;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Response monitor: every ack/err must match the oldest outstanding expectation.
   always @(posedge clk) begin : monitor
      logic [1:0] kind;
      exp_t       e;
      #1;
      if (read || write) chk("rw_exclusive", {31'b0, read & write}, 32'd0);
      if (i_ack || d_ack || i_err || d_err) begin
         chk("one_response", $countones({i_ack, d_ack, i_err, d_err}), 32'd1);
         kind = i_ack ? 2'd0 : d_ack ? 2'd1 : i_err ? 2'd2 : 2'd3;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_response: got kind %0d expected none", kind);
         end else begin
            e = sb.pop_front();
            if (kind !== e.kind) begin
               errors++;
               $display("FAIL response_kind: got %0d expected %0d", kind, e.kind);
            end
            if (e.chk) chk("rdata", (kind == 2'd0) ? i_rdata : d_rdata, e.rd);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drop_reqs();
      i_req = 1'b0;
      d_req = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      bit   seen;
      readdata    = v.rdata;
      waitrequest = (v.waits > 0);
      if (v.is_d) begin
         d_req    = 1'b1;
         d_we     = v.we;
         d_size   = v.size;
         d_signed = v.sgn;
         d_addr   = v.addr;
         d_wdata  = v.wdata;
      end else begin
         i_req  = 1'b1;
         i_addr = v.addr;
      end
      e.kind = v.exp_err ? (v.is_d ? 2'd3 : 2'd2) : (v.is_d ? 2'd1 : 2'd0);
      e.chk  = !v.exp_err && !v.we;
      e.rd   = v.exp_rd;
      sb.push_back(e);
      seen = 0;
      for (int n = 0; n < 10 && !seen; n++) begin
         tick();
         if (read || write || i_err || d_err) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL start_timeout: got no bus cycle or err expected one at %h", v.addr);
         drop_reqs();
         waitrequest = 1'b0;
         return;
      end
      if (v.exp_err) begin
         chk("no_bus_on_err", {29'b0, read, write, busy}, 32'd0);
         drop_reqs();
         tick();
         chk("idle_after_err", {29'b0, read, write, busy}, 32'd0);
         return;
      end
      chk("address", address, v.addr & 32'hFFFF_FFFC);
      chk("strobe", {30'b0, read, write}, v.we ? 32'd1 : 32'd2);
      chk("byteenable", {28'b0, byteenable}, {28'b0, v.exp_be});
      chk("writedata", writedata, v.we ? v.exp_wd : 32'd0);
      chk("busy_acc", {31'b0, busy}, 32'd1);
      for (int n = 0; n < v.waits; n++) begin
         tick();
         chk("strobe_held", {30'b0, read, write}, v.we ? 32'd1 : 32'd2);
      end
      waitrequest = 1'b0;
      tick();
      chk("ack", {30'b0, i_ack, d_ack}, v.is_d ? 32'd1 : 32'd2);
      chk("strobe_clear", {30'b0, read, write}, 32'd0);
      chk("writedata_clear", writedata, 32'd0);
      drop_reqs();
   endtask

   initial begin
      bit seen;
      exp_t e;
      //            is_d we size       sgn  addr          wdata         rdata         wt err be       wd            rd
      vecs[0]  = '{1'b0, 0, SIZE_WORD, 0, 32'h0000_1000, 32'h0,        32'h2402_000A, 0, 0, 4'hF,    32'h0,        32'h2402_000A};
      vecs[1]  = '{1'b1, 0, SIZE_BYTE, 1, 32'h0000_0203, 32'h0,        32'h80FF_1234, 3, 0, 4'b1000, 32'h0,        32'hFFFF_FF80};
      vecs[2]  = '{1'b1, 0, SIZE_BYTE, 0, 32'h0000_0203, 32'h0,        32'h80FF_1234, 3, 0, 4'b1000, 32'h0,        32'h0000_0080};
      vecs[3]  = '{1'b1, 1, SIZE_HALF, 0, 32'h0000_0102, 32'hDEAD_BEEF, 32'h0,        1, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
      vecs[4]  = '{1'b1, 0, SIZE_WORD, 0, 32'h0000_0006, 32'h0,        32'h0,        0, 1, 4'h0,    32'h0,        32'h0};
      vecs[5]  = '{1'b0, 0, SIZE_WORD, 0, 32'h0000_1002, 32'h0,        32'h0,        0, 1, 4'h0,    32'h0,        32'h0};
      vecs[6]  = '{1'b1, 0, SIZE_HALF, 1, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 0, 0, 4'b1100, 32'h0,        32'hFFFF_8001};
      vecs[7]  = '{1'b1, 0, SIZE_HALF, 0, 32'h0000_0000, 32'h0,        32'h1234_F00D, 2, 0, 4'b0011, 32'h0,        32'h0000_F00D};
      vecs[8]  = '{1'b1, 1, SIZE_BYTE, 0, 32'h0000_0301, 32'h0000_00A5, 32'h0,        0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
      vecs[9]  = '{1'b1, 1, SIZE_WORD, 0, 32'h0000_0400, 32'h1234_5678, 32'h0,        0, 0, 4'hF,    32'h1234_5678, 32'h0};
      vecs[10] = '{1'b1, 1, SIZE_HALF, 0, 32'h0000_0103, 32'h0000_1111, 32'h0,        0, 1, 4'h0,    32'h0,        32'h0};
      vecs[11] = '{1'b1, 0, SIZE_BYTE, 1, 32'h0000_0001, 32'h0,        32'h0000_7F00, 0, 0, 4'b0010, 32'h0,        32'h0000_007F};
      vecs[12] = '{1'b1, 0, SIZE_WORD, 1, 32'h0000_0008, 32'h0,        32'hCAFE_BABE, 1, 0, 4'hF,    32'h0,        32'hCAFE_BABE};

      tick();
      tick();
      chk("reset_bus", {address[29:0], read, write}, 32'd0);
      chk("reset_lanes", {20'b0, byteenable, 4'b0, i_ack, i_err, d_ack, d_err, busy}, 32'd0);
      chk("reset_data", i_rdata | d_rdata | writedata, 32'd0);
      reset = 1'b0;
      tick();

      foreach (vecs[i]) begin
         run_vec(vecs[i]);
         tick();
      end

      // Reset while stalled abandons the fetch with no acknowledge.
      waitrequest = 1'b1;
      i_req       = 1'b1;
      i_addr      = 32'h0000_0500;
      seen = 0;
      for (int n = 0; n < 10 && !seen; n++) begin
         tick();
         if (read) seen = 1;
      end
      chk("abort_started", {31'b0, seen}, 32'd1);
      reset = 1'b1;
      tick();
      chk("abort_cleared", {30'b0, read, busy}, 32'd0);
      i_req = 1'b0;
      tick();
      reset       = 1'b0;
      waitrequest = 1'b0;
      for (int n = 0; n < 4; n++) tick();

      // No grant while inactive; the held request proceeds once active returns.
      active   = 1'b0;
      i_req    = 1'b1;
      i_addr   = 32'h0000_0600;
      readdata = 32'h0BAD_F00D;
      for (int n = 0; n < 5; n++) begin
         tick();
         chk("inactive_no_read", {30'b0, read, busy}, 32'd0);
      end
      e = '{kind: 2'd0, chk: 1'b1, rd: 32'h0BAD_F00D};
      sb.push_back(e);
      active = 1'b1;
      seen = 0;
      for (int n = 0; n < 10 && !seen; n++) begin
         tick();
         if (read) seen = 1;
      end
      chk("active_resumes", {31'b0, seen}, 32'd1);
      tick();
      chk("active_ack", {31'b0, i_ack}, 32'd1);
      i_req = 1'b0;
      tick();

      // Round-robin with both requesters held: data wins the first tie after reset.
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      readdata = 32'h55AA_33CC;
      d_we     = 1'b0;
      d_size   = SIZE_WORD;
      d_signed = 1'b0;
      d_addr   = 32'h0000_3000;
      i_addr   = 32'h0000_2000;
      for (int n = 0; n < 4; n++) begin
         e = '{kind: (n % 2 == 0) ? 2'd1 : 2'd0, chk: 1'b1, rd: 32'h55AA_33CC};
         sb.push_back(e);
      end
      i_req = 1'b1;
      d_req = 1'b1;
      for (int n = 0; n < 4; n++) begin
         seen = 0;
         for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (read || write) seen = 1;
         end
         chk("rr_started", {31'b0, seen}, 32'd1);
         chk("rr_grant", address, (n % 2 == 0) ? 32'h0000_3000 : 32'h0000_2000);
         chk("rr_is_read", {30'b0, read, write}, 32'd2);
         tick();
         if (n == 3) drop_reqs();
      end
      for (int n = 0; n < 4; n++) tick();
      chk("rr_idle", {30'b0, read, busy}, 32'd0);

      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
